// File: rtl/mixcol_engine.sv
// MixColumns / InvMixColumns engine with COLS_PER_CYCLE column lanes that are reused
// across the four columns of a block. Handshakes are valid/ready on both sides.
module mixcol_engine #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         mode_i,
  input  logic [127:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int unsigned NCYC = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LastCnt = 2'(NCYC - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic [127:0] work_q, work_d;

  // GF(2^8) multiply by x.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    int          r1, r2, r3;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      if (inv) begin
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r]) ^ (x8[r1] ^ x2[r1] ^ a[r1]) ^
                           (x8[r2] ^ x4[r2] ^ a[r2]) ^ (x8[r3] ^ a[r3]);
      end else begin
        res[31-8*r -: 8] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      end
    end
    return res;
  endfunction

  logic [31:0] cols    [4];
  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign cols[c] = work_q[127-32*c -: 32];
  end

  // Column lanes: lane g handles column cnt*COLS_PER_CYCLE + g.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign col_idx[g] = 2'(32'(cnt_q) * COLS_PER_CYCLE + g);
    assign col_out[g] = mix_col(cols[col_idx[g]], mode_q);
  end

  // Next-state: accept, transform one column group per edge, then hold result until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      StIdle: begin
        if (valid_i) begin
          work_d  = data_i;
          mode_d  = mode_i;
          cnt_d   = 2'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int c = 0; c < 4; c++) begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            if (col_idx[g] == 2'(c)) work_d[127-32*c -: 32] = col_out[g];
          end
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = 2'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign busy_o  = (state_q == StBusy) || (state_q == StDone);
  assign data_o  = work_q;

endmodule

// File: tb/tb_mixcol_engine.sv
// Directed bench for mixcol_engine with one instance per lane count (1, 2, 4).
module tb_mixcol_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   valid_i, ready_o, mode_i, valid_o, ready_i, busy_o;
  logic [127:0] data_i [3];
  logic [127:0] data_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] PlainV = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] MixedV = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] FixInV = 128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6;
  localparam logic [127:0] FixOutV = 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mixcol_engine #(
      .COLS_PER_CYCLE(1 << k)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .valid_i(valid_i[k]),
      .ready_o(ready_o[k]),
      .mode_i (mode_i[k]),
      .data_i (data_i[k]),
      .valid_o(valid_o[k]),
      .ready_i(ready_i[k]),
      .data_o (data_o[k]),
      .busy_o (busy_o[k])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Push one block into instance k; called away from a clock edge. Scrambles mode/data inputs
  // while busy, holds ready_i low for 'hold' cycles in DONE, then takes the result.
  task automatic run_block(input int k, input logic [127:0] din, input logic mode,
                           input int hold, output logic [127:0] dout);
    int lat;
    logic [127:0] first;
    check_eq("ready_before_accept", 128'(ready_o[k]), 128'd1);
    valid_i[k] = 1'b1;
    data_i[k]  = din;
    mode_i[k]  = mode;
    @(posedge clk); #1;
    valid_i[k] = 1'b0;
    check_eq("busy_after_accept", 128'(busy_o[k]), 128'd1);
    lat = 0;
    while (!valid_o[k] && lat < 20) begin
      mode_i[k] = ~mode_i[k];
      data_i[k] = rnd128();
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 128'(lat), 128'(4 >> k));
    first = data_o[k];
    for (int i = 0; i < hold; i++) begin
      valid_i[k] = ~valid_i[k];
      data_i[k]  = rnd128();
      mode_i[k]  = ~mode_i[k];
      @(posedge clk); #1;
      check_eq("bp_valid", 128'(valid_o[k]), 128'd1);
      check_eq("bp_data", data_o[k], first);
      check_eq("bp_ready", 128'(ready_o[k]), 128'd0);
    end
    valid_i[k] = 1'b0;
    dout = data_o[k];
    ready_i[k] = 1'b1;
    @(posedge clk); #1;
    ready_i[k] = 1'b0;
    check_eq("valid_after_take", 128'(valid_o[k]), 128'd0);
    check_eq("ready_after_take", 128'(ready_o[k]), 128'd1);
    check_eq("data_held_idle", data_o[k], dout);
  endtask

  initial begin
    logic [127:0] res, orig, fwd;
    rst     = 1'b1;
    valid_i = '0;
    mode_i  = '0;
    ready_i = '0;
    for (int k = 0; k < 3; k++) data_i[k] = '0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", 128'(ready_o[k]), 128'd1);
      check_eq("rst_valid", 128'(valid_o[k]), 128'd0);
      check_eq("rst_busy", 128'(busy_o[k]), 128'd0);
      check_eq("rst_data", data_o[k], 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors on every lane count.
    for (int k = 0; k < 3; k++) begin
      run_block(k, PlainV, 1'b0, 0, res);
      check_eq("fwd_kat", res, MixedV);
      run_block(k, MixedV, 1'b1, 0, res);
      check_eq("inv_kat", res, PlainV);
      run_block(k, FixInV, 1'b0, 0, res);
      check_eq("fixed_point", res, FixOutV);
    end

    // Backpressure with ignored valid_i pulses.
    run_block(0, PlainV, 1'b0, 10, res);
    check_eq("bp_result", res, MixedV);

    // Asynchronous abort at cnt = 2 on the single-lane instance.
    valid_i[0] = 1'b1;
    data_i[0]  = PlainV;
    mode_i[0]  = 1'b0;
    @(posedge clk); #1;
    valid_i[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("abort_valid", 128'(valid_o[0]), 128'd0);
    check_eq("abort_data", data_o[0], 128'd0);
    check_eq("abort_ready", 128'(ready_o[0]), 128'd1);
    check_eq("abort_busy", 128'(busy_o[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, MixedV, 1'b1, 0, res);
    check_eq("after_abort", res, PlainV);

    // Random round trips spread over the three instances.
    for (int i = 0; i < 1000; i++) begin
      orig = rnd128();
      run_block(i % 3, orig, 1'b0, 0, fwd);
      run_block(i % 3, fwd, 1'b1, 0, res);
      check_eq("roundtrip", res, orig);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mixcol_engine.md
MIXCOL_ENGINE -- requirements
Module: mixcol_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, number of 32-bit columns transformed per clock; legal values 1, 2, 4.
REQ-002 SHALL have parameter NCYC, derived as 4/COLS_PER_CYCLE, not overridable, giving the processing cycles per block.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  input block valid.
REQ-006 ready_o  output  1  engine can accept a block.
REQ-007 mode_i  input  1  0 = forward MixColumns, 1 = InvMixColumns; sampled only at acceptance.
REQ-008 data_i  input  128  input state; column c = data_i[127-32c -: 32]; row r byte of column c = data_i[127-32c-8r -: 8].
REQ-009 valid_o  output  1  result valid.
REQ-010 ready_i  input  1  downstream accepts result.
REQ-011 data_o  output  128  result state, same byte mapping as data_i.
REQ-012 busy_o  output  1  high in BUSY or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 ready_o SHALL equal (state == IDLE); no input is accepted in BUSY or DONE.
REQ-015 Acceptance SHALL occur on a rising edge with valid_i && ready_o; data_i is copied to the working register, mode_i to the mode register, the column counter is cleared, and the state becomes BUSY.
REQ-016 In BUSY, each edge SHALL transform columns cnt*COLS_PER_CYCLE .. cnt*COLS_PER_CYCLE+COLS_PER_CYCLE-1 in place, then increment cnt.
REQ-017 On the edge that processes the last column group (cnt == NCYC-1), cnt SHALL wrap to 0 and the state SHALL become DONE.
REQ-018 valid_o SHALL be (state == DONE); it rises exactly NCYC edges after the acceptance edge (COLS_PER_CYCLE=4: 1 edge; =1: 4 edges).
REQ-019 data_o SHALL drive the working register; it is stable while valid_o && !ready_i.
REQ-020 In DONE, valid_o && ready_i SHALL move the state to IDLE on that edge; ready_o rises in the following cycle.
REQ-021 In IDLE, data_o SHALL hold the last result; valid_i while not ready SHALL be ignored without effect.
REQ-022 Forward column transform: out_r = 02*a_r ^ 03*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
REQ-023 Inverse column transform: out_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3), indices mod 4.
REQ-024 GF(2^8) multiply SHALL use xtime: shift left 1 and XOR 8'h1B when the pre-shift bit 7 is 1; constants are composed from x1/x2/x4/x8 terms.
REQ-025 Column logic SHALL be instantiated COLS_PER_CYCLE times and time-multiplexed over column groups; no 16-byte full-matrix datapath when COLS_PER_CYCLE < 4.
REQ-026 Changes to mode_i or data_i during BUSY or DONE SHALL not affect the result in progress.

Reset
REQ-027 While rst_i is high, the state SHALL be IDLE, cnt 0, mode register 0, working register 128'h0, valid_o 0, busy_o 0, ready_o 1.
REQ-028 rst_i asserted during BUSY or DONE SHALL abort immediately (asynchronously); the pending result is discarded and valid_o falls without a handshake.
REQ-029 Upon rst_i deassertion, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-030 Forward test: COLS_PER_CYCLE=1, mode 0, data_i = db135345_f20a225c_01010101_2d26314c -> data_o = 8e4da1bc_9fdc589d_01010101_4d7ebdf8; valid_o rises 4 edges after acceptance.
REQ-031 Inverse test: mode 1, data_i = 8e4da1bc_9fdc589d_01010101_4d7ebdf8 -> data_o = db135345_f20a225c_01010101_2d26314c; repeat for COLS_PER_CYCLE = 1, 2, 4 with latency 4, 2, 1.
REQ-032 Backpressure test: hold ready_i = 0 for 10 cycles in DONE -> valid_o stays 1 and data_o stays constant; ready_o stays 0; valid_i pulses are ignored.
REQ-033 Fixed-point test: data_i = c6c6c6c6_d4d4d4d5_01010101_c6c6c6c6, mode 0 -> data_o = c6c6c6c6_d5d5d7d6_01010101_c6c6c6c6.
REQ-034 Reset test: assert rst_i in BUSY at cnt = 2 -> valid_o = 0, data_o = 0, ready_o = 1 with no clock edge; the next block completes correctly.
REQ-035 Random round-trip test: 1000 random blocks, each forward then inverse -> output equals the original block; toggling mode_i mid-BUSY has no effect.
